// File: rtl/mc14500b_pkg.sv
// mc14500b_pkg: shared types for the MC14500B industrial control unit.
//   instruction_t : 4-bit opcode enum, NOPO (0x0) .. NOPF (0xF).
package mc14500b_pkg;

    typedef enum logic [3:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } instruction_t;

endpackage

// File: rtl/mc14500b_lu.sv
// mc14500b_lu: combinational logic unit of the MC14500B.
//   op      in  instruction_t  current opcode
//   rr      in  1              current result register
//   dg      in  1              gated data input (data_in & IEN)
//   rr_next out 1              next RR; opcodes outside LD..XNOR pass RR through
module mc14500b_lu
    import mc14500b_pkg::*;
(
    input  instruction_t op,
    input  logic         rr,
    input  logic         dg,
    output logic         rr_next
);

    always_comb begin
        rr_next = rr;
        case (op)
            LD:      rr_next = dg;
            LDC:     rr_next = ~dg;
            AND:     rr_next = rr & dg;
            ANDC:    rr_next = rr & ~dg;
            OR:      rr_next = rr | dg;
            ORC:     rr_next = rr | ~dg;
            XNOR:    rr_next = ~(rr ^ dg);
            default: rr_next = rr;
        endcase
    end

endmodule

// File: rtl/mc14500b_icu.sv
// mc14500b_icu: 1-bit industrial control unit (Motorola MC14500B instruction set).
// Executes one instruction per rising clk edge; all outputs are registered.
//   clk      in   1  system clock
//   rst      in   1  asynchronous active-low reset
//   data_in  in   1  data bus bit D
//   i        in   4  opcode (instruction_t encoding)
//   write    out  1  store strobe
//   data_out out  1  store data, held between stores
//   jmp      out  1  JMP strobe
//   rtn      out  1  RTN strobe
//   flag_o   out  1  NOPO strobe
//   flag_f   out  1  NOPF strobe
//   rr_out   out  1  current result register
// Configuration: define MC14500B_SKIP_EN to enable SKZ/RTN skip behaviour;
// when undefined the skip latch is tied 0 (SKZ is a NOP, RTN only pulses rtn).
module mc14500b_icu
    import mc14500b_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic [3:0] i,
    output logic       write,
    output logic       data_out,
    output logic       jmp,
    output logic       rtn,
    output logic       flag_o,
    output logic       flag_f,
    output logic       rr_out
);

    instruction_t op;
    logic         rr, ien, oen, skip;
    logic         dg, rr_next;

    assign op     = instruction_t'(i);
    assign dg     = data_in & ien;
    assign rr_out = rr;

    mc14500b_lu u_lu (
        .op      (op),
        .rr      (rr),
        .dg      (dg),
        .rr_next (rr_next)
    );

    // Main state and strobes. A pending skip turns the whole instruction into
    // a NOP, so every update below is gated by ~skip.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr       <= 1'b0;
            ien      <= 1'b0;
            oen      <= 1'b0;
            data_out <= 1'b0;
            write    <= 1'b0;
            jmp      <= 1'b0;
            rtn      <= 1'b0;
            flag_o   <= 1'b0;
            flag_f   <= 1'b0;
        end else begin
            write  <= 1'b0;
            jmp    <= 1'b0;
            rtn    <= 1'b0;
            flag_o <= 1'b0;
            flag_f <= 1'b0;
            if (!skip) begin
                rr <= rr_next;
                case (op)
                    NOPO: flag_o <= 1'b1;
                    STO:  if (oen) begin data_out <= rr;  write <= 1'b1; end
                    STOC: if (oen) begin data_out <= ~rr; write <= 1'b1; end
                    IEN:  ien    <= data_in;
                    OEN:  oen    <= data_in;
                    JMP:  jmp    <= 1'b1;
                    RTN:  rtn    <= 1'b1;
                    NOPF: flag_f <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef MC14500B_SKIP_EN
    // Skip always clears after one instruction, so a skipped SKZ/RTN cannot
    // re-arm it and skips never chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            skip <= 1'b0;
        else if (skip)
            skip <= 1'b0;
        else if (op == RTN)
            skip <= 1'b1;
        else if (op == SKZ)
            skip <= ~rr;
        else
            skip <= 1'b0;
    end
`else
    assign skip = 1'b0;
`endif

endmodule

// File: tb/tb_mc14500b_icu.sv
module tb_mc14500b_icu;

`ifdef MC14500B_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_in = 1'b0;
    logic [3:0] i = 4'h0;
    logic       write, data_out, jmp, rtn, flag_o, flag_f, rr_out;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit m_rr, m_ien, m_oen, m_skip, m_dout;
    bit m_wr, m_jmp, m_rtn, m_fo, m_ff;

    mc14500b_icu dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .i        (i),
        .write    (write),
        .data_out (data_out),
        .jmp      (jmp),
        .rtn      (rtn),
        .flag_o   (flag_o),
        .flag_f   (flag_f),
        .rr_out   (rr_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: got %b want %b (t=%0t)", tag, obs, exp, $time);
            $error("%s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rr_out"},   rr_out,   m_rr);
        chk({tag, ".data_out"}, data_out, m_dout);
        chk({tag, ".write"},    write,    m_wr);
        chk({tag, ".jmp"},      jmp,      m_jmp);
        chk({tag, ".rtn"},      rtn,      m_rtn);
        chk({tag, ".flag_o"},   flag_o,   m_fo);
        chk({tag, ".flag_f"},   flag_f,   m_ff);
    endtask

    task automatic model_reset();
        m_rr = 0; m_ien = 0; m_oen = 0; m_skip = 0; m_dout = 0;
        m_wr = 0; m_jmp = 0; m_rtn = 0; m_fo = 0; m_ff = 0;
    endtask

    // Instruction semantics straight from the opcode table.
    task automatic model_step(input int op, input bit d);
        bit dg;
        dg = d & m_ien;
        m_wr = 0; m_jmp = 0; m_rtn = 0; m_fo = 0; m_ff = 0;
        if (m_skip) begin
            m_skip = 0;
        end else begin
            case (op)
                0:  m_fo = 1;
                1:  m_rr = dg;
                2:  m_rr = !dg;
                3:  m_rr = m_rr && dg;
                4:  m_rr = m_rr && !dg;
                5:  m_rr = m_rr || dg;
                6:  m_rr = m_rr || !dg;
                7:  m_rr = (m_rr == dg);
                8:  if (m_oen) begin m_dout = m_rr;  m_wr = 1; end
                9:  if (m_oen) begin m_dout = !m_rr; m_wr = 1; end
                10: m_ien = d;
                11: m_oen = d;
                12: m_jmp = 1;
                13: begin m_rtn = 1; m_skip = SKIP_EN; end
                14: m_skip = SKIP_EN && (m_rr == 0);
                default: m_ff = 1;
            endcase
        end
    endtask

    // Drive between edges, execute on posedge, check 1 time unit later.
    task automatic exec(input string tag, input int op, input bit d);
        i = op[3:0];
        data_in = d;
        @(posedge clk);
        #1;
        model_step(op, d);
        chk_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        chk_all("reset");
        rst = 1'b1;

        // basic load/logic/store
        exec("ien1", 10, 1);
        exec("oen1", 11, 1);
        exec("ld1",  1, 1);
        chk("ld1.rr_is_1", rr_out, 1'b1);
        exec("or0",  5, 0);
        exec("and0", 3, 0);
        chk("and0.rr_is_0", rr_out, 1'b0);
        exec("sto",  8, 0);
        chk("sto.write_is_1", write, 1'b1);
        exec("nopo", 0, 0);
        chk("nopo.write_dropped", write, 1'b0);
        chk("nopo.flag_o_is_1", flag_o, 1'b1);
        exec("nopf_after_nopo", 15, 0);

        // input masking
        exec("ien0", 10, 0);
        exec("ldc_masked", 2, 1);
        chk("ldc_masked.rr_is_1", rr_out, 1'b1);

        // output gating
        exec("oen0", 11, 0);
        exec("sto_gated", 8, 1);
        chk("sto_gated.no_write", write, 1'b0);
        exec("oen1b", 11, 1);
        exec("stoc", 9, 0);

        // skip on zero
        exec("ien1b", 10, 1);
        exec("ld0", 1, 0);
        exec("skz_rr0", 14, 0);
        exec("ld1_after_skz", 1, 1);
        exec("ld1", 1, 1);
        exec("skz_rr1", 14, 0);
        exec("ld0_after_skz", 1, 0);

        // return / jump
        exec("rtn", 13, 0);
        exec("nopf_after_rtn", 15, 0);
        exec("jmp", 12, 0);
        exec("nopf_after_jmp", 15, 0);
        exec("skz_then_skz", 14, 0);
        exec("skz_second", 14, 0);
        exec("rtn_after_skz", 13, 0);

        // randomized program
        for (int k = 0; k < 600; k++) begin
            exec("rand", int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
        end

        // mid-program reset with RR=1 and a live write strobe
        exec("pre_ien", 10, 1);
        exec("pre_oen", 11, 1);
        exec("pre_ld", 1, 1);
        exec("pre_sto", 8, 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        chk("async_rst.rr_zero", rr_out, 1'b0);
        #1;
        rst = 1'b1;
        exec("post_rst_ld_masked", 1, 1);
        exec("post_rst_ien", 10, 1);
        exec("post_rst_ld", 1, 1);
        exec("post_rst_sto_gated", 8, 0);
        for (int k = 0; k < 200; k++) begin
            exec("rand2", int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
